hold_fifo_arb: RTL and testbench
================================

# hold_fifo_arb

Round-robin drain arbiter that shares one downstream write FIFO among `N_CH` Aurora hold FIFOs. Each hold FIFO buffers received Aurora words. This block selects one non-empty channel at a time and issues read strobes to it in bounded bursts. It forwards the read data, tagged with its channel number, to the downstream FIFO's write port. It sits between the per-lane hold FIFOs and the shared DMA/cPCI write FIFO.

## Interface
- `N_CH`, default 4: number of hold-FIFO channels, 2..8.
- `BURST_MAX`, default 16: maximum reads per grant, 1..255.
- `CH_W`, default 3: width of the channel tag. Must satisfy 2^CH_W ≥ N_CH.
- `clk_i`, input, 1: single clock. All logic is synchronous to it.
- `reset_n_i`, input, 1: reset, synchronous, active-low.
- `ch_empty_i`, input, N_CH: per-channel hold-FIFO empty flag.
- `ch_dat_i`, input, 32*N_CH: per-channel hold-FIFO read data. Channel k occupies bits [32k+31:32k]. Data appears 1 cycle after the read strobe (standard FIFO, not first-word-fall-through).
- `ch_rd_o`, output, N_CH: per-channel read strobe. Onehot or zero.
- `fifo_full_i`, input, 1: downstream FIFO almost-full. Must assert with ≥2 free slots remaining.
- `fifo_wr_o`, output, 1: downstream write strobe.
- `fifo_wr_dat_o`, output, 32: downstream write data.
- `fifo_wr_ch_o`, output, CH_W: channel tag of `fifo_wr_dat_o`.
- `grant_o`, output, N_CH: current grant, onehot or zero. Provided for status and debug.

## Operation
- **States:**
  - IDLE: no grant.
  - GRANT: one channel owns the port.
- **IDLE:**
  - Scan the requests (`~ch_empty_i`) starting at `last+1` modulo N_CH, where `last` is the most recently granted channel.
  - On a hit, register the grant to channel g, clear the burst counter, and go to GRANT.
  - If no channel requests, stay in IDLE.
- **GRANT, read strobe:**
  - `ch_rd_o[g] = ~ch_empty_i[g] & ~fifo_full_i & (cnt < BURST_MAX)`. This is combinational from registered state and the inputs.
  - `ch_rd_o` is forced to 0 while `reset_n_i` is 0.
- **Burst counter:**
  - `cnt` increments on every read.
  - Width is 8 bits, and it never wraps because it is bounded by BURST_MAX.
- **GRANT exit:** go to IDLE when the read count reaches BURST_MAX, or when `ch_empty_i[g]` is high in GRANT. Set `last <= g` on exit.
- **Back-pressure:** `fifo_full_i` only stalls reads. It does not end the grant and does not advance `cnt`.
- **Simultaneous conditions:** if `fifo_full_i` and `ch_empty_i[g]` are both high, the empty condition wins and the grant ends.
- **Datapath:**
  - Pipeline stage 1 registers `rd_any` and the tag.
  - Stage 2 registers `ch_dat_i[g_d1]` into `fifo_wr_dat_o`, and `rd_any_d1` into `fifo_wr_o`.
  - The tag travels with the data.
- **Reset mid-burst:**
  - All state, pipeline and outputs clear in the next cycle.
  - In-flight words are dropped. The caller resets the hold FIFOs at the same time.

## Timing
- **Reset values:**
  - `ch_rd_o` = 0.
  - `fifo_wr_o` = 0.
  - `fifo_wr_dat_o` = 0.
  - `fifo_wr_ch_o` = 0.
  - `grant_o` = 0.
  - State = IDLE, `last` = N_CH-1 so that the first scan starts at channel 0, `cnt` = 0.
- **Latency:**
  - Read strobe at cycle t produces `fifo_wr_o` at t+2.
  - Request visible in IDLE at t gives the grant at t+1 and the first read at t+1.
- **Throughput:**
  - One word per cycle within a burst.
  - One dead cycle (IDLE) between grants.
- **Overrun margin:** `fifo_full_i` has a 2-cycle pipeline between strobe and write. The downstream almost-full threshold must leave ≥2 slots.

## Configuration
- Macro `HOLD_FIFO_ARB_PRIO0_EN`.
- **Defined:**
  - Channel 0 has strict priority in IDLE. It wins whenever it is non-empty, regardless of `last`.
  - Its burst limit is still BURST_MAX.
  - The other channels are round-robin among themselves.
- **Undefined:** pure round-robin across all channels.

## Structure
- Shared package `hold_fifo_pkg`:
  - State enum encoding: IDLE=0, GRANT=1.
  - Data width constant 32.
  - Burst counter width constant 8.
- One sub-module, `rr_pick`. It is purely combinational: it takes a request vector and a last-pointer and returns a onehot next grant plus a valid flag. It is reused by the PRIO0 variant with channel 0 masked out.

## Test plan
- **Single channel:** reset, then channel 1 non-empty with 5 words, full=0.
  - Grant at t+1.
  - 5 reads on consecutive cycles.
  - `fifo_wr_o` high for 5 cycles starting at t+3, with tag 1 and data in order.
  - Returns to IDLE.
- **Burst limit:** all 4 channels hold 40 words, BURST_MAX=16.
  - Grant order is 0,1,2,3,0.
  - Exactly 16 writes per grant.
  - One idle cycle between grants.
  - Total 160 writes with no loss.
- **Back-pressure:** hold `fifo_full_i` high for 10 cycles mid-burst.
  - `ch_rd_o` drops in the same cycle.
  - `fifo_wr_o` stops 2 cycles later.
  - The grant is kept and `cnt` is unchanged; the burst completes after release.
- **Empty and full together:** `ch_empty_i[g]` and `fifo_full_i` rise together.
  - The grant ends and the next channel is granted.
  - No write occurs with stale data.
- **Reset mid-burst:** `reset_n_i`=0 for 1 cycle during the 8th read.
  - All outputs are 0 on the next edge.
  - After release, the first grant goes to channel 0.
- **With `HOLD_FIFO_ARB_PRIO0_EN`:** channels 0 and 2 are continuously non-empty.
  - Channel 0 is granted after every grant exit.
  - Channel 2 is granted only while channel 0 is empty.

Source files
------------

// File: rtl/hold_fifo_pkg.sv
// rtl/hold_fifo_pkg.sv - shared state encoding, widths and helpers for hold_fifo_arb
package hold_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  // Index of the set bit in a onehot vector of up to 8 channels; 0 when empty.
  function automatic logic [7:0] onehot_idx(logic [7:0] oh);
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hold_fifo_arb_rr_pick.sv
// rtl/hold_fifo_arb_rr_pick.sv - combinational round-robin picker, first request after last_i
module rr_pick #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [N-1:0] gnt_o,
  output logic         vld_o
);

  logic [N-1:0] gnt;
  logic         found;

  // Walk offsets 1..N from last_i; the first requesting channel wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req_i[j] && (((int'(last_i) + off) % N) == j)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign gnt_o = gnt;
  assign vld_o = found;

endmodule

// File: rtl/hold_fifo_arb.sv
// rtl/hold_fifo_arb.sv - round-robin burst drain of N_CH hold FIFOs into one tagged write port
// Optional HOLD_FIFO_ARB_PRIO0_EN: channel 0 wins every idle scan while non-empty.
module hold_fifo_arb
  import hold_fifo_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int BURST_MAX = 16,
  parameter int CH_W      = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [N_CH-1:0]        ch_empty_i,
  input  logic [DATA_W*N_CH-1:0] ch_dat_i,
  output logic [N_CH-1:0]        ch_rd_o,
  input  logic                   fifo_full_i,
  output logic                   fifo_wr_o,
  output logic [DATA_W-1:0]      fifo_wr_dat_o,
  output logic [CH_W-1:0]        fifo_wr_ch_o,
  output logic [N_CH-1:0]        grant_o
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
  localparam logic [CH_W-1:0]  LAST_RST  = CH_W'(N_CH - 1);

  arb_state_e          state_q, state_d;
  logic [N_CH-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     g_q, g_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_CH-1:0]     rd_d1_q, rd_d1_d;
  logic [CH_W-1:0]     tag_d1_q, tag_d1_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wr_dat_q, wr_dat_d;
  logic [CH_W-1:0]     wr_ch_q, wr_ch_d;

  logic [N_CH-1:0]     req;
  logic [N_CH-1:0]     pick_req;
  logic [N_CH-1:0]     pick_gnt;
  logic                pick_vld;
  logic [N_CH-1:0]     sel_gnt;
  logic                sel_vld;
  logic                g_empty;
  logic                rd_en;
  logic [N_CH-1:0]     rd_vec;

  assign req = ~ch_empty_i;

`ifdef HOLD_FIFO_ARB_PRIO0_EN
  assign pick_req = {req[N_CH-1:1], 1'b0};
`else
  assign pick_req = req;
`endif

  rr_pick #(
    .N (N_CH),
    .W (CH_W)
  ) u_rr_pick (
    .req_i  (pick_req),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .vld_o  (pick_vld)
  );

  always_comb begin
    sel_gnt = pick_gnt;
    sel_vld = pick_vld;
`ifdef HOLD_FIFO_ARB_PRIO0_EN
    if (req[0]) begin
      sel_gnt = {{(N_CH-1){1'b0}}, 1'b1};
      sel_vld = 1'b1;
    end
`endif
  end

  // Read strobe is combinational so a full or empty flag stalls in the same cycle.
  always_comb begin
    g_empty = |(ch_empty_i & grant_q);
    rd_en   = reset_n_i && (state_q == GRANT) && !g_empty && !fifo_full_i
              && (cnt_q < BURST_LIM);
    rd_vec  = rd_en ? grant_q : '0;
  end

  assign ch_rd_o = rd_vec;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = GRANT;
          grant_d = sel_gnt;
          g_d     = CH_W'(onehot_idx(8'(sel_gnt)));
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rd_en) cnt_d = cnt_q + 1'b1;
        // Leaving on the final read keeps the gap between grants at one cycle.
        if (g_empty || (cnt_d == BURST_LIM)) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = g_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_d1_d  = rd_vec;
    tag_d1_d = g_q;
    wr_d     = |rd_d1_q;
    wr_dat_d = wr_dat_q;
    wr_ch_d  = wr_ch_q;
    if (|rd_d1_q) begin
      wr_dat_d = '0;
      for (int k = 0; k < N_CH; k++) begin
        if (rd_d1_q[k]) wr_dat_d = ch_dat_i[k*DATA_W +: DATA_W];
      end
      wr_ch_d = tag_d1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      g_q      <= '0;
      last_q   <= LAST_RST;
      cnt_q    <= '0;
      rd_d1_q  <= '0;
      tag_d1_q <= '0;
      wr_q     <= 1'b0;
      wr_dat_q <= '0;
      wr_ch_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      g_q      <= g_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rd_d1_q  <= rd_d1_d;
      tag_d1_q <= tag_d1_d;
      wr_q     <= wr_d;
      wr_dat_q <= wr_dat_d;
      wr_ch_q  <= wr_ch_d;
    end
  end

  assign grant_o       = grant_q;
  assign fifo_wr_o     = wr_q;
  assign fifo_wr_dat_o = wr_dat_q;
  assign fifo_wr_ch_o  = wr_ch_q;

endmodule

// File: tb/tb_hold_fifo_arb.sv
// tb/tb_hold_fifo_arb.sv - self-checking bench for hold_fifo_arb with hold-FIFO models and scoreboard
module tb_hold_fifo_arb;

  localparam int N  = 4;
  localparam int BM = 16;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      ch_empty;
  logic [32*N-1:0]   ch_dat;
  logic [N-1:0]      ch_rd;
  logic              full;
  logic              wr;
  logic [31:0]       wr_dat;
  logic [CW-1:0]     wr_ch;
  logic [N-1:0]      grant;

  hold_fifo_arb #(
    .N_CH      (N),
    .BURST_MAX (BM),
    .CH_W      (CW)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .ch_empty_i    (ch_empty),
    .ch_dat_i      (ch_dat),
    .ch_rd_o       (ch_rd),
    .fifo_full_i   (full),
    .fifo_wr_o     (wr),
    .fifo_wr_dat_o (wr_dat),
    .fifo_wr_ch_o  (wr_ch),
    .grant_o       (grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [CW-1:0] ch;
    logic [31:0]   dat;
  } exp_t;

  typedef struct packed {
    logic [0:3][7:0] words;
    logic [3:0]      n_gnt;
    logic [47:0]     ord;
    logic [95:0]     len;
  } vec_t;

  exp_t         sbq[$];
  vec_t         vt[6];
  int           avail[N];
  int           seq[N];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           n_wr, n_rd;
  logic [N-1:0] s_rd, s_gnt;
  logic         s_wr;
  logic [31:0]  s_dat;
  logic [CW-1:0] s_ch;
  int           glog_ch[32];
  int           glog_len[32];
  int           ng, idle_start, first_gnt_cyc, first_wr_cyc;
  bit           in_grant, gap_exp;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh2i(logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] mkword(int k, int s);
    return 32'hA500_0000 | (32'(k) << 16) | (32'(s) & 32'h0000_FFFF);
  endfunction

  function automatic bit model_idle();
    bit r = (sbq.size() == 0) && !in_grant;
    for (int k = 0; k < N; k++) if (avail[k] != 0) r = 1'b0;
    return r;
  endfunction

  task automatic upd_empty();
    for (int k = 0; k < N; k++) ch_empty[k] = (avail[k] == 0);
  endtask

  task automatic load(int k, int n);
    avail[k] += n;
    upd_empty();
  endtask

  task automatic clear_log();
    ng = 0; in_grant = 1'b0; gap_exp = 1'b0; idle_start = 0;
    first_gnt_cyc = -1; first_wr_cyc = -1; n_wr = 0; n_rd = 0;
  endtask

  // One clock: sample and score at negedge, then advance the hold-FIFO models after the edge.
  task automatic cycle();
    int pk;
    bit pend;
    pend = 1'b0;
    pk   = 0;
    @(negedge clk);
    s_rd = ch_rd; s_gnt = grant; s_wr = wr; s_dat = wr_dat; s_ch = wr_ch;
    if (s_wr === 1'b1) begin
      n_wr++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      chk("wr_pending", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        chk("wr_due", sbq[0].due, cyc);
        chk("wr_ch", 32'(s_ch), 32'(sbq[0].ch));
        chk("wr_dat", s_dat, sbq[0].dat);
        void'(sbq.pop_front());
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      chk("wr_missing", 32'(s_wr), 1);
      void'(sbq.pop_front());
    end
    if (s_gnt !== '0 && !$isunknown(s_gnt) && !in_grant) begin
      in_grant = 1'b1;
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      if (gap_exp) chk("idle_gap", cyc - idle_start, 1);
      if (ng < 32) begin glog_ch[ng] = oh2i(s_gnt); glog_len[ng] = 0; end
      ng++;
    end else if (s_gnt === '0 && in_grant) begin
      in_grant   = 1'b0;
      idle_start = cyc;
      gap_exp    = 1'b0;
      for (int k = 0; k < N; k++) if (avail[k] != 0) gap_exp = 1'b1;
    end
    if (s_rd !== '0 && !$isunknown(s_rd)) begin
      pk = oh2i(s_rd);
      chk("rd_in_grant", 32'(s_rd), 32'(s_gnt));
      chk("rd_not_full", 32'(full), 0);
      chk("rd_not_empty", 32'(avail[pk] > 0), 1);
      if (avail[pk] > 0) begin
        pend = 1'b1;
        sbq.push_back('{cyc + 2, CW'(pk), mkword(pk, seq[pk])});
      end
      if (in_grant && ng > 0 && ng <= 32) glog_len[ng-1]++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend) begin
      ch_dat[pk*32 +: 32] = mkword(pk, seq[pk]);
      seq[pk]++;
      avail[pk]--;
      n_rd++;
    end
    upd_empty();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    cycle();
    sbq.delete();
    for (int k = 0; k < N; k++) avail[k] = 0;
    upd_empty();
    reset_n = 1'b1;
  endtask

  task automatic run_done(string tag);
    bit done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      cycle();
      done = model_idle();
    end
    chk({tag, "_drained"}, 32'(done), 1);
  endtask

  task automatic wait_reads(int n);
    for (int c = 0; c < 200 && n_rd < n; c++) cycle();
    chk("reads_reached", 32'(n_rd >= n), 1);
  endtask

  initial begin
    int ld, tot;
    vt[0] = '{{8'd0, 8'd5, 8'd0, 8'd0},    4'd1,  48'h1000_0000_0000, 96'h05000000_00000000_00000000};
`ifdef HOLD_FIFO_ARB_PRIO0_EN
    vt[1] = '{{8'd40, 8'd40, 8'd40, 8'd40}, 4'd12, 48'h0001_2312_3123, 96'h10100810_10101010_10080808};
`else
    vt[1] = '{{8'd40, 8'd40, 8'd40, 8'd40}, 4'd12, 48'h0123_0123_0123, 96'h10101010_10101010_08080808};
`endif
    vt[2] = '{{8'd3, 8'd0, 8'd20, 8'd1},   4'd4,  48'h0232_0000_0000, 96'h03100104_00000000_00000000};
    vt[3] = '{{8'd0, 8'd0, 8'd0, 8'd17},   4'd2,  48'h3300_0000_0000, 96'h10010000_00000000_00000000};
    vt[4] = '{{8'd1, 8'd1, 8'd1, 8'd1},    4'd4,  48'h0123_0000_0000, 96'h01010101_00000000_00000000};
`ifdef HOLD_FIFO_ARB_PRIO0_EN
    vt[5] = '{{8'd20, 8'd0, 8'd40, 8'd0},  4'd5,  48'h0022_2000_0000, 96'h10041010_08000000_00000000};
`else
    vt[5] = '{{8'd20, 8'd0, 8'd40, 8'd0},  4'd5,  48'h0202_2000_0000, 96'h10100410_08000000_00000000};
`endif

    ch_empty = '1; ch_dat = '0; full = 1'b0; reset_n = 1'b0;
    for (int k = 0; k < N; k++) begin avail[k] = 0; seq[k] = 0; end
    clear_log();
    cycle();
    cycle();
    chk("rst_rd", 32'(s_rd), 0);
    chk("rst_wr", 32'(s_wr), 0);
    chk("rst_dat", s_dat, 0);
    chk("rst_ch", 32'(s_ch), 0);
    chk("rst_grant", 32'(s_gnt), 0);
    reset_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      do_reset();
      clear_log();
      tot = 0;
      for (int k = 0; k < N; k++) begin
        load(k, int'(vt[v].words[k]));
        tot += int'(vt[v].words[k]);
      end
      ld = cyc;
      run_done($sformatf("v%0d", v));
      chk($sformatf("v%0d_grant_lat", v), first_gnt_cyc - ld, 1);
      chk($sformatf("v%0d_wr_lat", v), first_wr_cyc - ld, 3);
      chk($sformatf("v%0d_n_grants", v), ng, int'(vt[v].n_gnt));
      chk($sformatf("v%0d_total_wr", v), n_wr, tot);
      for (int i = 0; i < int'(vt[v].n_gnt) && i < ng; i++) begin
        chk($sformatf("v%0d_order%0d", v, i), glog_ch[i], 32'(vt[v].ord[47-4*i -: 4]));
        chk($sformatf("v%0d_len%0d", v, i), glog_len[i], 32'(vt[v].len[95-8*i -: 8]));
      end
    end

    // Back-pressure mid-burst: strobe drops at once, writes drain 2 cycles later, grant kept.
    do_reset();
    clear_log();
    load(0, 30);
    wait_reads(5);
    full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("bp_rd_stalled", 32'(s_rd), 0);
      chk("bp_grant_kept", 32'(s_gnt), 32'h1);
      if (i < 2) chk("bp_wr_inflight", 32'(s_wr), 1);
      else       chk("bp_wr_stopped", 32'(s_wr), 0);
    end
    full = 1'b0;
    run_done("bp");
    chk("bp_len0", glog_len[0], BM);
    chk("bp_ch1", glog_ch[1], 0);
    chk("bp_len1", glog_len[1], 30 - BM);
    chk("bp_total_wr", n_wr, 30);

    // Granted channel empties in the same cycle full rises: empty wins.
    do_reset();
    clear_log();
    load(1, 6);
    load(2, 4);
    wait_reads(6);
    full = 1'b1;
    cycle();
    chk("ef_rd", 32'(s_rd), 0);
    chk("ef_grant_exit", 32'(s_gnt), 32'h2);
    cycle();
    chk("ef_idle", 32'(s_gnt), 0);
    cycle();
    chk("ef_next_grant", 32'(s_gnt), 32'h4);
    chk("ef_rd_held", 32'(s_rd), 0);
    full = 1'b0;
    run_done("ef");
    chk("ef_total_wr", n_wr, 10);
    chk("ef_n_grants", ng, 2);

    // Reset during the 8th read of a burst.
    do_reset();
    clear_log();
    load(2, 20);
    wait_reads(7);
    reset_n = 1'b0;
    cycle();
    chk("mrst_rd_forced", 32'(s_rd), 0);
    sbq.delete();
    for (int k = 0; k < N; k++) avail[k] = 0;
    upd_empty();
    reset_n = 1'b1;
    cycle();
    chk("mrst_rd", 32'(s_rd), 0);
    chk("mrst_wr", 32'(s_wr), 0);
    chk("mrst_dat", s_dat, 0);
    chk("mrst_ch", 32'(s_ch), 0);
    chk("mrst_grant", 32'(s_gnt), 0);
    clear_log();
    load(0, 3);
    load(2, 3);
    run_done("mrst");
    chk("mrst_first_ch", glog_ch[0], 0);
    chk("mrst_second_ch", glog_ch[1], 2);
    chk("mrst_total_wr", n_wr, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
